// File: rtl/xalu_ctrl_pkg.sv
// Shared XALU definitions: opcode encodings, default cycle counts, FSM and
// op-kind types, plus small decode helpers used by the controller.
package xalu_ctrl_pkg;

    localparam int DATA_W = 32;

    // E-stage XALUOp encodings, shared with the decoder and hazard unit
    localparam logic [2:0] XOP_NOP   = 3'b000;
    localparam logic [2:0] XOP_MTHI  = 3'b001;
    localparam logic [2:0] XOP_MTLO  = 3'b010;
    localparam logic [2:0] XOP_RSVD  = 3'b011;
    localparam logic [2:0] XOP_MULT  = 3'b100;
    localparam logic [2:0] XOP_MULTU = 3'b101;
    localparam logic [2:0] XOP_DIV   = 3'b110;
    localparam logic [2:0] XOP_DIVU  = 3'b111;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } xalu_state_e;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } xalu_kind_t;

    function automatic logic is_start(input logic [2:0] op);
        return (op == XOP_MULT) || (op == XOP_MULTU) ||
               (op == XOP_DIV)  || (op == XOP_DIVU);
    endfunction

    function automatic xalu_kind_t decode_kind(input logic [2:0] op);
        xalu_kind_t k;
        k.is_div    = (op == XOP_DIV)  || (op == XOP_DIVU);
        k.is_signed = (op == XOP_MULT) || (op == XOP_DIV);
        return k;
    endfunction

endpackage

// File: rtl/xalu_ctrl_if.sv
// E-stage request / HI-LO readback bundle between the pipeline and xalu_ctrl.
interface xalu_ctrl_if;
    import xalu_ctrl_pkg::*;

    logic [2:0]        xalu_op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              cancel;
    logic              read_hi;
    logic              busy;
    logic [DATA_W-1:0] result;

    modport master (
        output xalu_op, rs_val, rt_val, cancel, read_hi,
        input  busy, result
    );

    modport slave (
        input  xalu_op, rs_val, rt_val, cancel, read_hi,
        output busy, result
    );

endinterface

// File: rtl/xalu_ctrl_arith.sv
// Combinational multiply/divide datapath: 32x32 operands to a 64-bit {hi,lo}.
// Divide-by-zero and the signed overflow case are resolved here so the
// controller only ever commits a well-defined value.
module xalu_arith
    import xalu_ctrl_pkg::*;
(
    input  xalu_kind_t        kind_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    // Full-width product; operands widened by sign or zero extension first
    function automatic logic [63:0] mul_full(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] prod;
        ea   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        eb   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        prod = ea * eb;
        return prod;
    endfunction

    // Returns {remainder, quotient}; signed case works on magnitudes so the
    // quotient truncates toward zero and the remainder follows the dividend
    function automatic logic [63:0] div_full(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end
        if (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            return {32'd0, 32'h8000_0000};
        end
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ua    = neg_a ? (~a + 32'd1) : a;
        ub    = neg_b ? (~b + 32'd1) : b;
        q     = ua / ub;
        r     = ua % ub;
        if (neg_a ^ neg_b) begin
            q = ~q + 32'd1;
        end
        if (neg_a) begin
            r = ~r + 32'd1;
        end
        return {r, q};
    endfunction

    // Select the unit matching the captured op kind
    always_comb begin
        if (kind_i.is_div) begin
            {hi_o, lo_o} = div_full(a_i, b_i, kind_i.is_signed);
        end else begin
            {hi_o, lo_o} = mul_full(a_i, b_i, kind_i.is_signed);
        end
    end

endmodule

// File: rtl/xalu_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO. A start in IDLE
// captures the operands and op kind; the arithmetic result of those captured
// operands is the pending value, committed to {HI,LO} on the last edge of the
// busy window. Cancel aborts without touching HI/LO.
module xalu_ctrl
    import xalu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    xalu_ctrl_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    xalu_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    xalu_kind_t        kind_q,  kind_d;
    logic [DATA_W-1:0] opa_q,   opa_d;
    logic [DATA_W-1:0] opb_q,   opb_d;
    logic [DATA_W-1:0] hi_q,    hi_d;
    logic [DATA_W-1:0] lo_q,    lo_d;

    logic [DATA_W-1:0] pend_hi;
    logic [DATA_W-1:0] pend_lo;

    xalu_arith u_arith (
        .kind_i (kind_q),
        .a_i    (opa_q),
        .b_i    (opb_q),
        .hi_o   (pend_hi),
        .lo_o   (pend_lo)
    );

    // State, counter, captured operands and HI/LO; reset clears everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kind_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: cancel dominates, then IDLE start/MT*, then RUN countdown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (bus.cancel) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_start(bus.xalu_op)) begin
                        kind_d  = decode_kind(bus.xalu_op);
                        opa_d   = bus.rs_val;
                        opb_d   = bus.rt_val;
                        cnt_d   = kind_d.is_div ? DIV_LOAD : MULT_LOAD;
                        state_d = S_RUN;
                    end else if (bus.xalu_op == XOP_MTHI) begin
                        hi_d = bus.rs_val;
                    end else if (bus.xalu_op == XOP_MTLO) begin
                        lo_d = bus.rs_val;
                    end
                end
                S_RUN: begin
                    // Starts and MT* are ignored while an operation is in flight
                    if (cnt_q == CNT_ONE) begin
                        hi_d    = pend_hi;
                        lo_d    = pend_lo;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.result = bus.read_hi ? hi_q : lo_q;

endmodule

// File: doc/xalu_ctrl.md
# xalu_ctrl

Multi-cycle multiply/divide controller owning the HI/LO register pair for the five-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and sequences each multi-cycle operation with a countdown. It drives `busy`, which the hazard unit combines with the E-stage XALU opcode to stall MFHI/MFLO/XALU instructions in D. It also returns HI or LO for MFHI/MFLO.

## Interface
- `MULT_CYCLES`, default 5: busy-window length for MULT/MULTU, ≥1.
- `DIV_CYCLES`, default 10: busy-window length for DIV/DIVU, ≥1.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `xalu_op` in 3: E-stage XALUOp.
  - 000 NOP, 001 MTHI, 010 MTLO, 011 reserved (no-op).
  - 100 MULT, 101 MULTU, 110 DIV, 111 DIVU.
- `rs_val` in 32: forwarded rs operand; dividend, or MTHI/MTLO source.
- `rt_val` in 32: forwarded rt operand; divisor.
- `cancel` in 1: synchronous abort from exception/flush logic.
- `read_hi` in 1: 1 selects HI onto `result`, 0 selects LO.
- `busy` out 1: operation in flight.
- `result` out 32: combinational `read_hi ? HI : LO`.

## Operation
- States: IDLE and RUN. RUN carries a registered op kind (mul/div, signed flag), a captured 64-bit pending result and a down-counter.
- IDLE, `xalu_op` in 1xx: capture operands and compute the pending result, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
- RUN: decrement every cycle.
  - Counter reaches 1: on that edge commit pending to {HI,LO}, clear busy, return to IDLE.
- MTHI/MTLO in IDLE: write `rs_val` to HI/LO at the edge.
  - MTHI/MTLO while RUN is ignored. The hazard unit guarantees this does not occur; the bench asserts on it.
- Start op while RUN: ignored, no restart.
- Multiply: 64-bit product, signed (MULT) or unsigned (MULTU). HI = [63:32], LO = [31:0].
- Divide: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `cancel` has highest priority:
  - Forces IDLE and clears busy/counter at the edge; HI/LO unchanged.
  - A start or MT* presented in the same cycle is dropped.

## Timing
- Reset (asserted low, async):
  - `busy` = 0, HI = LO = 0, state IDLE, counter 0.
  - `result` = 0 for either `read_hi` value.
- Start sampled at edge T:
  - `busy` = 1 for exactly N cycles, from after T through edge T+N.
  - HI/LO hold the new value from edge T+N; `busy` falls on the same edge.
- `busy` is 0 in the start cycle itself; the hazard unit covers that cycle by decoding `xalu_op`.
- MTHI/MTLO: one-edge latency; `result` reflects the new value the following cycle.
- `result` is purely combinational from HI/LO and `read_hi`; no bypass of pending or MT* data.
- Reset asserted mid-RUN: immediate abort; pending result discarded, HI/LO = 0.

## Structure
- Shared header `xalu_defs`: the 3-bit XALUOp encodings and default cycle counts. The E-stage decoder and the hazard unit share these.
- One combinational sub-module `xalu_arith`: ops and operands in, 64-bit {hi,lo} out, with the div-by-zero and overflow rules inside.
- `xalu_ctrl` holds the FSM, counter, pending and HI/LO registers.

## Test plan
- Reset low mid-simulation → `busy` = 0; `result` = 0x00000000 with `read_hi` = 0 and 1.
- MULT rs = 0xFFFFFFFE, rt = 3 → `busy` high 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. Same with MULTU → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV rs = 0xFFFFFFF9, rt = 2 → `busy` high 10 cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU same operands → LO = 0x7FFFFFFC, HI = 0x00000001.
- DIVU 5/0 → LO = 0xFFFFFFFF, HI = 0x00000005. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTLO 0x1234 → LO = 0x1234 next cycle. Then DIV with `cancel` pulsed in busy cycle 3 → `busy` low next cycle, LO still 0x1234. Second MULT issued while busy is ignored, window length unchanged.
- `reset` asserted low in busy cycle 4 of MULT → `busy` = 0 immediately; HI = LO = 0; no late commit after release.
